// File: rtl/axi_fetch_line.sv
// axi_fetch_line: one-line fetch buffer that fills itself from the boot ROM with aligned AXI INCR bursts.
module axi_fetch_line #(
  parameter int LINE_WORDS = 4,
  parameter int LB = $clog2(LINE_WORDS) + 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ack,
  output logic [31:0] cpu_data,
  output logic        cpu_err,
  input  logic        flush,
  output logic        busy,
  output logic        axi_ARVALID,
  input  logic        axi_ARREADY,
  output logic [31:0] axi_AR,
  output logic [1:0]  axi_ARBURST,
  output logic [7:0]  axi_ARLEN,
  input  logic [31:0] axi_R,
  input  logic        axi_RVALID,
  output logic        axi_RREADY,
  input  logic        axi_RLAST
);
  localparam int IW = LB - 2;
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL = CW'(LINE_WORDS);
  typedef enum logic [1:0] {IDLE, AR, RD, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] line_q [LINE_WORDS];
  logic [31:LB] tag_q, tag_d;
  logic [31:2] req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic valid_q, valid_d, flushed_q, flushed_d;
  logic ack_q, ack_d, err_q, err_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0] data_q, data_d, ar_q, ar_d;
  logic [IW-1:0] idx, cpu_idx;
  logic beat, we, unused_addr;
  assign unused_addr = ^cpu_addr[1:0];
  assign idx = req_q[LB-1:2];
  assign cpu_idx = cpu_addr[LB-1:2];
  assign beat = axi_RVALID & rready_q;
  assign cnt_inc = cnt_q == FULL ? FULL : cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    tag_d = tag_q;
    req_d = req_q;
    cnt_d = cnt_q;
    valid_d = valid_q & ~flush;
    flushed_d = flushed_q | flush;
    ack_d = 1'b0;
    err_d = 1'b0;
    data_d = data_q;
    arvalid_d = arvalid_q;
    ar_d = ar_q;
    rready_d = rready_q;
    we = 1'b0;
    case (state_q)
      IDLE: if (cpu_req && !ack_q) begin
        if (valid_q && !flush && cpu_addr[31:LB] == tag_q) begin
          ack_d = 1'b1;
          data_d = line_q[cpu_idx];
        end else begin
          req_d = cpu_addr[31:2];
          ar_d = {cpu_addr[31:LB], {LB{1'b0}}};
          arvalid_d = 1'b1;
          cnt_d = '0;
          flushed_d = 1'b0;
          state_d = AR;
        end
      end
      AR: if (axi_ARREADY) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = RD;
      end
      RD: if (beat) begin
        we = cnt_q < FULL;
        cnt_d = cnt_inc;
        if (axi_RLAST) begin
          rready_d = 1'b0;
          tag_d = req_q[31:LB];
          valid_d = cnt_inc == FULL && !flushed_q && !flush;
          ack_d = 1'b1;
          err_d = cnt_inc != FULL;
          // the requested word may be arriving on this very beat
          data_d = cnt_inc != FULL ? '0 :
                   (cnt_q < FULL && cnt_q[IW-1:0] == idx) ? axi_R : line_q[idx];
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      flushed_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      data_q <= '0;
      arvalid_q <= 1'b0;
      ar_q <= '0;
      rready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      flushed_q <= flushed_d;
      ack_q <= ack_d;
      err_q <= err_d;
      data_q <= data_d;
      arvalid_q <= arvalid_d;
      ar_q <= ar_d;
      rready_q <= rready_d;
    end
  end
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    if (we) line_q[cnt_q[IW-1:0]] <= axi_R;
  end
  assign cpu_ack = ack_q;
  assign cpu_data = data_q;
  assign cpu_err = err_q;
  assign busy = state_q != IDLE;
  assign axi_ARVALID = arvalid_q;
  assign axi_AR = ar_q;
  assign axi_RREADY = rready_q;
  assign axi_ARBURST = 2'b01;
  assign axi_ARLEN = 8'(LINE_WORDS - 1);
endmodule

// File: doc/axi_fetch_line.md
# axi_fetch_line

Read-only line-fill front end that sits directly upstream of the boot ROM AXI slave and acts as its only AXI read master. It accepts single-word fetch requests from the CPU and serves hits from a one-line buffer. On a miss it issues a line-aligned AXI INCR burst, captures the returned beats, and then answers the pending request. The block turns word-at-a-time instruction fetch into efficient ROM bursts and isolates the CPU from the AXI handshake.

## Interface

Parameters:
- LINE_WORDS, default 4: words per line; power of two, range 2..16. Burst is ARLEN = LINE_WORDS-1.
- LB, derived as log2(LINE_WORDS)+2: byte-offset bits inside a line.

Ports:
- clk  in  1  single clock; every register is clocked on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- cpu_req  in  1  fetch request; held high with a stable cpu_addr until cpu_ack.
- cpu_addr  in  32  byte address; bits [1:0] are ignored.
- cpu_ack  out  1  one-cycle pulse; cpu_data and cpu_err are valid in this cycle.
- cpu_data  out  32  fetched word.
- cpu_err  out  1  the fill ended short; cpu_data is 0.
- flush  in  1  invalidates the line buffer.
- busy  out  1  high while not in IDLE.
- axi_ARVALID  out  1  read address valid.
- axi_ARREADY  in  1  read address accepted.
- axi_AR  out  32  burst start address, line-aligned (low LB bits are 0).
- axi_ARBURST  out  2  constant 2'b01 (INCR).
- axi_ARLEN  out  8  constant LINE_WORDS-1.
- axi_R  in  32  read data.
- axi_RVALID  in  1  read beat valid.
- axi_RREADY  out  1  ready for a beat.
- axi_RLAST  in  1  last beat of the burst.

## Operation

- State: buf[LINE_WORDS] x 32, tag[31:LB], line_valid, req_addr[31:2], beat counter cnt (log2(LINE_WORDS)+1 bits).
- FSM states: IDLE, AR, RD, RESP.
- **IDLE**
  - cpu_req is sampled only when cpu_ack is low.
  - Hit (line_valid and cpu_addr[31:LB] == tag):
    - next cycle drives cpu_ack=1 and cpu_data = buf[cpu_addr[LB-1:2]];
    - the FSM stays in IDLE.
  - Miss:
    - latch req_addr;
    - next cycle drives axi_ARVALID=1 and axi_AR = {cpu_addr[31:LB], LB'b0};
    - clear cnt; go to AR.
- **AR**
  - axi_ARVALID and axi_AR are held stable until a cycle with axi_ARREADY=1.
  - In that cycle ARVALID drops at the edge, RREADY rises, and the FSM goes to RD.
- **RD**
  - axi_RREADY=1.
  - Each cycle with RVALID&RREADY: if cnt < LINE_WORDS, write buf[cnt] = axi_R; then cnt++ (saturating).
  - Beats beyond LINE_WORDS are discarded.
  - On a beat with RLAST=1:
    - RREADY drops; tag = req_addr[31:LB];
    - line_valid is set only if the final cnt == LINE_WORDS;
    - go to RESP.
- **RESP**
  - cpu_ack=1 for one cycle.
  - If the line is valid: cpu_data = buf[req_addr[LB-1:2]], cpu_err=0.
  - Otherwise (short burst): cpu_data = 0, cpu_err=1.
  - Next state is IDLE.
- **flush**
  - Clears line_valid in any state.
  - flush together with a request in IDLE: the flush wins and the request is handled as a miss.
  - flush during RD: line_valid stays 0 after this fill. RESP still returns the captured word with cpu_err=0 if the burst was full.
- Address arithmetic is 32-bit. Line index wraps modulo 2^(32-LB); no wrap inside a burst because the start is line-aligned.

## Timing

- Reset values:
  - outputs: cpu_ack=0, cpu_data=0, cpu_err=0, busy=0, axi_ARVALID=0, axi_AR=0, axi_RREADY=0, axi_ARBURST=2'b01, axi_ARLEN=LINE_WORDS-1;
  - internal: line_valid=0, FSM=IDLE, cnt=0.
- Reset mid-fill: the next cycle is IDLE with ARVALID and RREADY low. The downstream slave is reset on the same rst; no stale-beat recovery is required.
- Hit latency: request sampled at edge N, cpu_ack high in cycle N+1.
- Miss latency: ARVALID rises at N+1. ack = (ARREADY wait) + (beats incl. stalls) + 1 cycle for RESP.
- Handshake rules:
  - ARVALID never drops without ARREADY.
  - RREADY is high only in RD.
  - cpu_ack is never high on two consecutive cycles.
  - New requests are accepted from the cycle after cpu_ack.
- Registered outputs only; no combinational path from an input to an output.

## Test plan

- Cold miss at addr 0x0000_0008, ROM words 0x11,0x22,0x33,0x44 at 0x0..0xC -> AR=0x0, ARLEN=3, ARBURST=01, four beats, ack with cpu_data=0x33, err=0.
- Hit: after the above, req 0x0000_000C -> ack exactly 1 cycle later, data 0x44, no ARVALID activity.
- Tag miss: req 0x0000_0010 -> new burst AR=0x10; then req 0x4 -> miss again, AR=0x0.
- Backpressure: ARREADY delayed 5 cycles and RVALID gaps between beats -> AR stable throughout, all beats captured in order, correct data.
- Short burst: slave asserts RLAST on beat 2 of 4 -> ack with cpu_err=1, data 0; next request to the same line misses.
- flush with a simultaneous hit-address request, and rst asserted in RD -> the request misses; after reset all outputs are at reset values and the next request misses.
